// File: rtl/sca_sequencer.sv
// Host-side sequencer for one sca_unlock measurement: serial pattern load,
// flip_clk burst, scan-chain capture and readback, all timed off sys_clk.
module sca_sequencer #(
   parameter int NUM_INS  = 8,
   parameter int NUM_OUTS = 8,
   parameter int CLK_DIV  = 4,
   parameter int FLIP_W   = 16
) (
   input  logic                 sys_clk,
   input  logic                 sca_reset,
   input  logic                 start,
   input  logic [2*NUM_INS-1:0] cfg_pattern,
   input  logic [FLIP_W-1:0]    cfg_flips,
   output logic                 busy,
   output logic                 done,
   output logic [NUM_OUTS-1:0]  result,
   output logic                 echo_err,
   output logic                 sr_clk,
   output logic                 sr_data,
   input  logic                 sr_echo,
   output logic                 flip_clk,
   output logic                 so_enable,
   output logic                 so_clk,
   input  logic                 so_data
);

   localparam int PW = 2 * NUM_INS;
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (PW > 1) ? $clog2(PW) : 1;
   localparam int OW = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD_HI, S_LOAD_LO, S_FLIP_HI, S_FLIP_LO,
      S_CAP_HI, S_CAP_LO, S_SH_HI, S_SH_LO, S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [TW-1:0]       r_timer;
   logic [BW-1:0]       r_bitCnt;
   logic [OW-1:0]       r_outCnt;
   logic [FLIP_W-1:0]   r_flipCnt;
   logic [PW-1:0]       r_pattern;
   logic [PW-1:0]       r_txShift;
   logic [PW-1:0]       r_echoShift;
   logic [PW-1:0]       r_lastPattern;
   logic [NUM_OUTS-1:0] r_shadow;
   logic [NUM_OUTS-1:0] r_result;
   logic                r_busy;
   logic                r_done;
   logic                r_echoErr;
   logic                r_srClk;
   logic                r_srData;
   logic                r_flipClk;
   logic                r_soEnable;
   logic                r_soClk;
   logic                w_accept;
   logic                w_phaseEnd;
   logic                w_lastBit;
   logic                w_lastOut;
   logic                w_nextTxBit;

   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_phaseEnd = (r_timer == TW'(CLK_DIV - 1));
   assign w_lastBit  = (r_bitCnt == BW'(PW - 1));
   assign w_lastOut  = (r_outCnt == OW'(NUM_OUTS - 1));

   always_comb begin
      w_nextState = r_state;
      w_nextTxBit = r_txShift[PW-1];
      case (r_state)
         S_IDLE:    if (start) w_nextState = S_LOAD_HI;
         S_LOAD_HI: if (w_phaseEnd) w_nextState = S_LOAD_LO;
         S_LOAD_LO: begin
            if (w_phaseEnd) begin
               if (!w_lastBit)            w_nextState = S_LOAD_HI;
               else if (r_flipCnt != '0)  w_nextState = S_FLIP_HI;
               else                       w_nextState = S_CAP_HI;
            end
         end
         S_FLIP_HI: if (w_phaseEnd) w_nextState = S_FLIP_LO;
         S_FLIP_LO: begin
            if (w_phaseEnd)
               w_nextState = (r_flipCnt == FLIP_W'(1)) ? S_CAP_HI : S_FLIP_HI;
         end
         S_CAP_HI:  if (w_phaseEnd) w_nextState = S_CAP_LO;
         S_CAP_LO:  if (w_phaseEnd) w_nextState = S_SH_HI;
         S_SH_HI:   if (w_phaseEnd) w_nextState = S_SH_LO;
         S_SH_LO:   if (w_phaseEnd) w_nextState = w_lastOut ? S_DONE : S_SH_HI;
         S_DONE:    w_nextState = S_IDLE;
         default:   w_nextState = S_IDLE;
      endcase
      // Bit presented on sr_data in the upcoming LOAD pair
      if (w_accept)
         w_nextTxBit = cfg_pattern[PW-1];
      else if ((r_state == S_LOAD_LO) && w_phaseEnd)
         w_nextTxBit = r_txShift[PW-2];
   end

   always_ff @(posedge sys_clk or negedge sca_reset) begin
      if (!sca_reset) begin
         r_state <= S_IDLE;
         r_timer <= '0;
      end else begin
         r_state <= w_nextState;
         if ((w_nextState != r_state) || (r_state == S_IDLE) || (r_state == S_DONE))
            r_timer <= '0;
         else
            r_timer <= r_timer + TW'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sca_reset) begin
      if (!sca_reset) begin
         r_bitCnt      <= '0;
         r_outCnt      <= '0;
         r_flipCnt     <= '0;
         r_pattern     <= '0;
         r_txShift     <= '0;
         r_echoShift   <= '0;
         r_lastPattern <= '0;
         r_shadow      <= '0;
         r_result      <= '0;
         r_echoErr     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pattern   <= cfg_pattern;
            r_txShift   <= cfg_pattern;
            r_echoShift <= r_lastPattern;
            r_flipCnt   <= cfg_flips;
            r_bitCnt    <= '0;
            r_outCnt    <= '0;
            r_echoErr   <= 1'b0;
         end
         // Loopback shows the previous run's pattern leaving the receiver
         if ((r_state == S_LOAD_HI) && w_phaseEnd && (sr_echo != r_echoShift[PW-1]))
            r_echoErr <= 1'b1;
         if ((r_state == S_LOAD_LO) && w_phaseEnd) begin
            r_txShift   <= r_txShift << 1;
            r_echoShift <= r_echoShift << 1;
            r_bitCnt    <= r_bitCnt + BW'(1);
         end
         if ((r_state == S_FLIP_LO) && w_phaseEnd)
            r_flipCnt <= r_flipCnt - FLIP_W'(1);
         if ((r_state == S_SH_HI) && w_phaseEnd)
            r_shadow <= (r_shadow << 1) | NUM_OUTS'(so_data);
         if ((r_state == S_SH_LO) && w_phaseEnd)
            r_outCnt <= r_outCnt + OW'(1);
         if (w_nextState == S_DONE) begin
            r_result      <= r_shadow;
            r_lastPattern <= r_pattern;
         end
      end
   end

   // Pins are registered copies of the next-state decode so they never glitch
   always_ff @(posedge sys_clk or negedge sca_reset) begin
      if (!sca_reset) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_srClk    <= 1'b0;
         r_srData   <= 1'b0;
         r_flipClk  <= 1'b0;
         r_soEnable <= 1'b0;
         r_soClk    <= 1'b0;
      end else begin
         r_busy     <= (w_nextState != S_IDLE) && (w_nextState != S_DONE);
         r_done     <= (w_nextState == S_DONE);
         r_srClk    <= (w_nextState == S_LOAD_HI);
         r_srData   <= ((w_nextState == S_LOAD_HI) || (w_nextState == S_LOAD_LO)) ? w_nextTxBit : 1'b0;
         r_flipClk  <= (w_nextState == S_FLIP_HI);
         r_soEnable <= (w_nextState == S_SH_HI) || (w_nextState == S_SH_LO);
         r_soClk    <= (w_nextState == S_CAP_HI) || (w_nextState == S_SH_HI);
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign echo_err  = r_echoErr;
   assign sr_clk    = r_srClk;
   assign sr_data   = r_srData;
   assign flip_clk  = r_flipClk;
   assign so_enable = r_soEnable;
   assign so_clk    = r_soClk;

endmodule

// File: tb/tb_sca_sequencer.sv
// Self-checking bench for sca_sequencer with behavioural models of the
// harness serial receiver and output scan chain.
module tb_sca_sequencer;

   localparam int NI = 4;
   localparam int NO = 4;
   localparam int CD = 2;
   localparam int FW = 16;

   typedef struct {
      logic [7:0]  pat;
      logic [15:0] flips;
      logic [3:0]  outs;
      int          forceBit;
      bit          midStart;
      int          expLen;
      logic [3:0]  expResult;
      bit          expErr;
   } vec_t;

   logic          sys_clk = 1'b0;
   logic          sca_reset = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    cfg_pattern = '0;
   logic [15:0]   cfg_flips = '0;
   logic          busy, done, echo_err, sr_clk, sr_data, sr_echo;
   logic          flip_clk, so_enable, so_clk, so_data;
   logic [3:0]    result;

   // Harness models
   logic [7:0]    rx = '0;
   logic [3:0]    sc = '0;
   logic [3:0]    dutOuts = '0;
   int            forceRise = -1;

   // Monitor state (monotonic; runs take deltas)
   int            srRises = 0, srFalls = 0, flipRises = 0, soFalls = 0;
   int            doneCnt = 0, flipBadWidth = 0, flipOutside = 0, curHigh = 0;
   logic [7:0]    srAcc = '0, echoAcc = '0;
   logic [4:0]    soEnAcc = '0;
   logic          lastEcho = 1'b0, pSr = 1'b0, pSo = 1'b0, pFlip = 1'b0;

   int            tests = 0;
   int            fails = 0;
   logic [7:0]    mdlLast = '0;
   vec_t          vecs[5];

   sca_sequencer #(.NUM_INS(NI), .NUM_OUTS(NO), .CLK_DIV(CD), .FLIP_W(FW)) dut (
      .sys_clk(sys_clk), .sca_reset(sca_reset), .start(start),
      .cfg_pattern(cfg_pattern), .cfg_flips(cfg_flips),
      .busy(busy), .done(done), .result(result), .echo_err(echo_err),
      .sr_clk(sr_clk), .sr_data(sr_data), .sr_echo(sr_echo),
      .flip_clk(flip_clk), .so_enable(so_enable), .so_clk(so_clk), .so_data(so_data)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sr_clk or negedge sca_reset) begin
      if (!sca_reset) rx <= '0;
      else            rx <= {rx[6:0], sr_data};
   end

   always @(negedge so_clk or negedge sca_reset) begin
      if (!sca_reset)     sc <= '0;
      else if (so_enable) sc <= {sc[2:0], 1'b0};
      else                sc <= dutOuts;
   end

   assign sr_echo = rx[7] ^ (srRises == forceRise);
   assign so_data = sc[3];

   always @(negedge sys_clk) begin
      if (!pSr && sr_clk) srRises++;
      if (sr_clk) lastEcho = rx[7] ^ (srRises == forceRise);
      if (pSr && !sr_clk) begin
         srFalls++;
         srAcc   = {srAcc[6:0], sr_data};
         echoAcc = {echoAcc[6:0], lastEcho};
      end
      if (!pFlip && flip_clk) flipRises++;
      if (flip_clk) curHigh++;
      else begin
         if (pFlip && sca_reset && (curHigh != CD)) flipBadWidth++;
         curHigh = 0;
      end
      if (flip_clk && (sr_clk || so_clk || so_enable)) flipOutside++;
      if (pSo && !so_clk) begin
         soFalls++;
         soEnAcc = {soEnAcc[3:0], so_enable};
      end
      if (done) doneCnt++;
      pSr   = sr_clk;
      pSo   = so_clk;
      pFlip = flip_clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int calcLen(input int flips);
      return 2 * CD * (2 * NI + flips + 1 + NO);
   endfunction

   // Launch one run and count cycles from the accept edge to the done cycle
   task automatic applyStimulus(input logic [7:0] pat, input logic [15:0] flips,
                                input logic [3:0] outs, input int forceBit,
                                input bit midStart, output int cyc);
      dutOuts     = outs;
      cfg_pattern = pat;
      cfg_flips   = flips;
      forceRise   = (forceBit < 0) ? -1 : srRises + forceBit + 1;
      start       = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      start = 1'b0;
      checkOutput("busy_after_start", 32'(busy), 32'(1));
      checkOutput("echo_err_cleared", 32'(echo_err), 32'(0));
      cyc = 0;
      while (!done && cyc < 500) begin
         @(negedge sys_clk);
         cyc++;
         if (midStart && cyc == 10) begin
            start       = 1'b1;
            cfg_pattern = ~pat;
            cfg_flips   = 16'd7;
         end else if (midStart && cyc == 11) begin
            start = 1'b0;
         end
      end
   endtask

   task automatic runVector(input string tag, input logic [7:0] pat, input logic [15:0] flips,
                            input logic [3:0] outs, input int forceBit, input bit midStart,
                            input int expLen, input logic [3:0] expResult, input bit expErr);
      int cyc;
      int bSrF, bFlip, bSoF, bDone, bBad, bOut;
      logic [7:0] mask;
      @(negedge sys_clk);
      bSrF = srFalls; bFlip = flipRises; bSoF = soFalls;
      bDone = doneCnt; bBad = flipBadWidth; bOut = flipOutside;
      applyStimulus(pat, flips, outs, forceBit, midStart, cyc);
      mask = (forceBit >= 0) ? (8'h80 >> forceBit) : 8'h00;
      checkOutput($sformatf("%s_len", tag), 32'(cyc), 32'(expLen));
      checkOutput($sformatf("%s_result", tag), 32'(result), 32'(expResult));
      checkOutput($sformatf("%s_busy_at_done", tag), 32'(busy), 32'(0));
      checkOutput($sformatf("%s_echo_err", tag), 32'(echo_err), 32'(expErr));
      checkOutput($sformatf("%s_sr_bits", tag), 32'(srAcc), 32'(pat));
      checkOutput($sformatf("%s_echo_bits", tag), 32'(echoAcc), 32'(mdlLast ^ mask));
      checkOutput($sformatf("%s_sr_falls", tag), 32'(srFalls - bSrF), 32'(2 * NI));
      checkOutput($sformatf("%s_flip_pulses", tag), 32'(flipRises - bFlip), 32'(flips));
      checkOutput($sformatf("%s_so_falls", tag), 32'(soFalls - bSoF), 32'(NO + 1));
      checkOutput($sformatf("%s_so_en_at_falls", tag), 32'(soEnAcc), 32'(5'b01111));
      checkOutput($sformatf("%s_flip_width", tag), 32'(flipBadWidth - bBad), 32'(0));
      checkOutput($sformatf("%s_flip_outside", tag), 32'(flipOutside - bOut), 32'(0));
      repeat (3) @(negedge sys_clk);
      checkOutput($sformatf("%s_done_count", tag), 32'(doneCnt - bDone), 32'(1));
      checkOutput($sformatf("%s_idle_after", tag), 32'(busy), 32'(0));
      mdlLast = pat;
   endtask

   initial begin
      int waitCyc;
      logic [7:0]  rPat;
      logic [15:0] rFlips;
      logic [3:0]  rOuts;
      int          rForce;

      vecs[0] = '{8'hA5, 16'd0, 4'hB, -1, 1'b0, 52, 4'hB, 1'b0};
      vecs[1] = '{8'h3C, 16'd3, 4'h6, -1, 1'b0, 64, 4'h6, 1'b0};
      vecs[2] = '{8'h5A, 16'd1, 4'h1,  2, 1'b0, 56, 4'h1, 1'b1};
      vecs[3] = '{8'hFF, 16'd0, 4'hF, -1, 1'b1, 52, 4'hF, 1'b0};
      vecs[4] = '{8'h00, 16'd2, 4'hD, -1, 1'b0, 60, 4'hD, 1'b0};

      #3 sca_reset = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkOutput("reset_outputs",
                  32'({busy, done, result, echo_err, sr_clk, sr_data, flip_clk, so_enable, so_clk}), 32'(0));
      sca_reset = 1'b1;
      repeat (2) @(negedge sys_clk);

      for (int i = 0; i < 5; i++)
         runVector($sformatf("vec%0d", i), vecs[i].pat, vecs[i].flips, vecs[i].outs,
                   vecs[i].forceBit, vecs[i].midStart, vecs[i].expLen,
                   vecs[i].expResult, vecs[i].expErr);

      // Reset asserted in the middle of the flip burst
      dutOuts     = 4'h9;
      cfg_pattern = 8'h96;
      cfg_flips   = 16'd6;
      forceRise   = -1;
      @(negedge sys_clk);
      start = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      start = 1'b0;
      waitCyc = 0;
      while (!flip_clk && waitCyc < 200) begin
         @(negedge sys_clk);
         waitCyc++;
      end
      checkOutput("reach_flip", 32'(flip_clk), 32'(1));
      #2 sca_reset = 1'b0;
      #1;
      checkOutput("midreset_outputs",
                  32'({busy, done, result, echo_err, sr_clk, sr_data, flip_clk, so_enable, so_clk}), 32'(0));
      repeat (2) @(negedge sys_clk);
      checkOutput("midreset_busy", 32'(busy), 32'(0));
      sca_reset = 1'b1;
      mdlLast   = 8'h00;
      repeat (2) @(negedge sys_clk);
      runVector("post_reset", 8'hC3, 16'd2, 4'h5, -1, 1'b0, 60, 4'h5, 1'b0);

      for (int i = 0; i < 6; i++) begin
         rPat   = 8'($urandom);
         rFlips = 16'($urandom_range(0, 4));
         rOuts  = 4'($urandom);
         rForce = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
         runVector($sformatf("rnd%0d", i), rPat, rFlips, rOuts, rForce, 1'b0,
                   calcLen(int'(rFlips)), rOuts, rForce >= 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
